// File: rtl/mult_product_accumulator_if.sv
//------------------------------------------------------------------------------
// Module     : mult_product_accumulator_if
// Description: Handshake bundle between an upstream multiplier, the product
//              accumulator and its downstream consumer.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface mult_product_accumulator_if #(
  parameter int PW = 16,
  parameter int AW = 24
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [7:0]    out_count;
  logic          out_ovf;

  // Producer / consumer side
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/mult_product_accumulator.sv
//------------------------------------------------------------------------------
// Module     : mult_product_accumulator
// Description: Sums blocks of up to LEN unsigned products into an AW-bit
//              accumulator and presents sum, count and overflow flag with a
//              valid/ready handshake. A block closes at LEN products or on
//              in_last.
//              Optional: define MULT_ACC_SAT_EN to saturate the accumulator
//              at all-ones on overflow instead of wrapping modulo 2^AW.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mult_product_accumulator #(
  parameter int PW  = 16,
  parameter int AW  = 24,
  parameter int LEN = 4
) (
  input  wire logic                clk,
  input  wire logic                rst,
  mult_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] C_LEN = 8'(LEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_nxt;
  logic [7:0]    r_count;
  logic [7:0]    w_count_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;

  logic          w_in_ready;
  logic          w_in_fire;
  logic          w_hold;
  logic [AW-1:0] w_base;
  logic [AW:0]   w_sum;
  logic          w_ovf_blk;
  logic [7:0]    w_count_inc;

  // in_ready is purely a function of state, never of any input
  assign w_in_ready = (r_state != S_HOLD);
  assign w_hold     = (r_state == S_HOLD);
  assign w_in_fire  = bus.in_valid & w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_hold;
  assign bus.out_sum   = w_hold ? r_acc   : '0;
  assign bus.out_count = w_hold ? r_count : 8'd0;
  assign bus.out_ovf   = w_hold ? r_ovf   : 1'b0;

  // Adder: a fresh block starts from zero, otherwise from the running sum;
  // the extra MSB captures the carry out of bit AW-1
  always_comb begin
    w_base      = (r_state == S_IDLE) ? '0 : r_acc;
    w_sum       = {1'b0, w_base} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};
    w_ovf_blk   = ((r_state == S_IDLE) ? 1'b0 : r_ovf) | w_sum[AW];
    w_count_inc = (r_state == S_IDLE) ? 8'd1 : r_count + 8'd1;
  end

  // Next-state and datapath update selection
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE, S_ACC: begin
        if (w_in_fire) begin
`ifdef MULT_ACC_SAT_EN
          // Once the block has overflowed the sum is pinned at all-ones
          w_acc_nxt = w_ovf_blk ? '1 : w_sum[AW-1:0];
`else
          w_acc_nxt = w_sum[AW-1:0];
`endif
          w_count_nxt = w_count_inc;
          w_ovf_nxt   = w_ovf_blk;
          if ((w_count_inc == C_LEN) || bus.in_last) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_ACC;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = 8'd0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
        w_count_nxt = 8'd0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, product count and overflow flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
//------------------------------------------------------------------------------
// Module     : tb_mult_product_accumulator
// Description: Self-checking bench for mult_product_accumulator. Three
//              instances: A (AW=24, LEN=4), B (AW=16, LEN=4), C (LEN=1).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mult_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_product_accumulator_if #(.PW(16), .AW(24)) ifa ();
  mult_product_accumulator_if #(.PW(16), .AW(16)) ifb ();
  mult_product_accumulator_if #(.PW(16), .AW(24)) ifc ();

  mult_product_accumulator #(.PW(16), .AW(24), .LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mult_product_accumulator #(.PW(16), .AW(16), .LEN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mult_product_accumulator #(.PW(16), .AW(24), .LEN(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [23:0] s;
    logic [7:0]  c;
    logic        o;
  } res_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t obs_q[$];
  res_t exp_q[$];
  bit   mon_en   = 1'b0;
  bit   rnd_ordy = 1'b0;

  // Random back-pressure on instance A
  always @(negedge clk) if (rnd_ordy) ifa.out_ready = ($urandom_range(0, 3) != 0);

  // Record every output transfer of instance A
  always @(negedge clk) begin
    #1;
    if (mon_en && ifa.out_valid && ifa.out_ready)
      obs_q.push_back({ifa.out_sum, ifa.out_count, ifa.out_ovf});
  end

  task automatic drive(input int d, input bit v, input logic [15:0] p, input bit l);
    case (d)
      0: begin ifa.in_valid = v; ifa.in_prod = p; ifa.in_last = l; end
      1: begin ifb.in_valid = v; ifb.in_prod = p; ifb.in_last = l; end
      default: begin ifc.in_valid = v; ifc.in_prod = p; ifc.in_last = l; end
    endcase
  endtask

  function automatic bit rdy(input int d);
    case (d)
      0: return ifa.in_ready;
      1: return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  // Offer one product from a negedge; returns at the negedge after acceptance
  task automatic send(input int d, input logic [15:0] p, input bit l);
    bit r;
    bit ok;
    ok = 1'b0;
    drive(d, 1'b1, p, l);
    for (int k = 0; k < 64 && !ok; k++) begin
      r = rdy(d);
      @(negedge clk);
      ok = r;
    end
    drive(d, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (!ok) $display("FAIL send_timeout dut=%0d: in_ready never 1, required 1 within 64 cycles", d);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0); drive(1, 0, 0, 0); drive(2, 0, 0, 0);
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0; ifc.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", ifa.out_valid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", ifa.in_ready); else n_pass++;
    n_checks++; if (ifa.out_sum !== 24'd0 || ifa.out_count !== 8'd0) $display("FAIL reset_outputs: got sum=%0d count=%0d required 0 0", ifa.out_sum, ifa.out_count); else n_pass++;
    n_checks++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) $display("FAIL reset_c: got rdy=%b vld=%b required 1 0", ifc.in_ready, ifc.out_valid); else n_pass++;
  endtask

  task automatic test_basic_block;
    ifa.out_ready = 1'b1;
    send(0, 3, 0); send(0, 5, 0); send(0, 7, 0); send(0, 9, 0);
    n_checks++; if (ifa.out_valid !== 1'b1) $display("FAIL basic_valid: got %b required 1", ifa.out_valid); else n_pass++;
    n_checks++; if (ifa.out_sum !== 24'd24 || ifa.out_count !== 8'd4 || ifa.out_ovf !== 1'b0)
      $display("FAIL basic_result: got sum=%0d count=%0d ovf=%b required 24 4 0", ifa.out_sum, ifa.out_count, ifa.out_ovf); else n_pass++;
    n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL basic_hold_ready: got %b required 0", ifa.in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) $display("FAIL basic_one_cycle: got vld=%b rdy=%b required 0 1", ifa.out_valid, ifa.in_ready); else n_pass++;
  endtask

  task automatic test_last_and_stall;
    ifa.out_ready = 1'b0;
    send(0, 10, 0); send(0, 20, 1);
    n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sum !== 24'd30 || ifa.out_count !== 8'd2 || ifa.in_ready !== 1'b0)
      $display("FAIL last_result: got vld=%b sum=%0d count=%0d rdy=%b required 1 30 2 0", ifa.out_valid, ifa.out_sum, ifa.out_count, ifa.in_ready); else n_pass++;
    drive(0, 1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sum !== 24'd30 || ifa.out_count !== 8'd2 || ifa.in_ready !== 1'b0)
        $display("FAIL stall_hold cycle %0d: got vld=%b sum=%0d count=%0d rdy=%b required 1 30 2 0", i, ifa.out_valid, ifa.out_sum, ifa.out_count, ifa.in_ready); else n_pass++;
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0);
    n_checks++; if (ifa.out_valid !== 1'b0 || ifa.out_sum !== 24'd0 || ifa.in_ready !== 1'b1)
      $display("FAIL stall_release: got vld=%b sum=%0d rdy=%b required 0 0 1", ifa.out_valid, ifa.out_sum, ifa.in_ready); else n_pass++;
    send(0, 1, 1);
    n_checks++; if (ifa.out_sum !== 24'd1 || ifa.out_count !== 8'd1) $display("FAIL stall_no_leak: got sum=%0d count=%0d required 1 1", ifa.out_sum, ifa.out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_valid_gaps;
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(0, pat[i][0], 16'd2, 1'b0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0);
    n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_sum !== 24'd8 || ifa.out_count !== 8'd4)
      $display("FAIL gaps_result: got vld=%b sum=%0d count=%0d required 1 8 4", ifa.out_valid, ifa.out_sum, ifa.out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [15:0] e1, e2;
`ifdef MULT_ACC_SAT_EN
    e1 = 16'hFFFF; e2 = 16'hFFFF;
`else
    e1 = 16'h0001; e2 = 16'h0001;
`endif
    ifb.out_ready = 1'b0;
    send(1, 16'hFFFF, 0); send(1, 16'h0002, 1);
    n_checks++; if (ifb.out_sum !== e1 || ifb.out_ovf !== 1'b1 || ifb.out_count !== 8'd2)
      $display("FAIL ovf_two: got sum=%h ovf=%b count=%0d required %h 1 2", ifb.out_sum, ifb.out_ovf, ifb.out_count, e1); else n_pass++;
    ifb.out_ready = 1'b1; @(negedge clk); ifb.out_ready = 1'b0;
    send(1, 16'hFFFF, 0); send(1, 16'h0002, 0); send(1, 16'h0000, 1);
    n_checks++; if (ifb.out_sum !== e2 || ifb.out_ovf !== 1'b1 || ifb.out_count !== 8'd3)
      $display("FAIL ovf_sticky: got sum=%h ovf=%b count=%0d required %h 1 3", ifb.out_sum, ifb.out_ovf, ifb.out_count, e2); else n_pass++;
    ifb.out_ready = 1'b1; @(negedge clk); ifb.out_ready = 1'b0;
    send(1, 16'h8000, 0); send(1, 16'h7FFF, 1);
    n_checks++; if (ifb.out_sum !== 16'hFFFF || ifb.out_ovf !== 1'b0)
      $display("FAIL ovf_edge: got sum=%h ovf=%b required ffff 0", ifb.out_sum, ifb.out_ovf); else n_pass++;
    ifb.out_ready = 1'b1; @(negedge clk);
    n_checks++; if (ifb.out_valid !== 1'b0 || ifb.out_ovf !== 1'b0) $display("FAIL ovf_cleared: got vld=%b ovf=%b required 0 0", ifb.out_valid, ifb.out_ovf); else n_pass++;
  endtask

  task automatic test_reset_mid_block;
    obs_q.delete();
    mon_en = 1'b1;
    ifa.out_ready = 1'b1;
    send(0, 5, 0); send(0, 6, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    n_checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) $display("FAIL rstmid_state: got vld=%b rdy=%b required 0 1", ifa.out_valid, ifa.in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) send(0, 1, 0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    n_checks++; if (obs_q.size() != 1) $display("FAIL rstmid_count: got %0d results required 1", obs_q.size());
    else begin
      n_pass++;
      n_checks++; if (obs_q[0].s !== 24'd4 || obs_q[0].c !== 8'd4) $display("FAIL rstmid_result: got sum=%0d count=%0d required 4 4", obs_q[0].s, obs_q[0].c); else n_pass++;
    end
  endtask

  task automatic test_len1;
    logic [15:0] p;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = 16'($urandom);
      send(2, p, 0);
      n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_sum !== {8'd0, p} || ifc.out_count !== 8'd1)
        $display("FAIL len1_block %0d: got vld=%b sum=%h count=%0d required 1 %h 1", i, ifc.out_valid, ifc.out_sum, ifc.out_count, p); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random_blocks;
    int          nb;
    int          l;
    bit          lst;
    logic [15:0] p;
    longint      total;
    res_t        e;
    obs_q.delete(); exp_q.delete();
    mon_en = 1'b1; rnd_ordy = 1'b1;
    nb = 40;
    for (int b = 0; b < nb; b++) begin
      l = $urandom_range(1, 4);
      lst = (l < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      total = 0;
      for (int j = 0; j < l; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        p = 16'($urandom);
        total += p;
        send(0, p, (j == l - 1) ? lst : 1'b0);
      end
      e.s = 24'(total);
      e.o = (total >= (64'd1 << 24));
`ifdef MULT_ACC_SAT_EN
      if (e.o) e.s = '1;
`endif
      e.c = 8'(l);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
    rnd_ordy = 1'b0; ifa.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d results required %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i])
        $display("FAIL rand_block %0d: got sum=%0d count=%0d ovf=%b required %0d %0d %b", i, obs_q[i].s, obs_q[i].c, obs_q[i].o, exp_q[i].s, exp_q[i].c, exp_q[i].o); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_block();
    test_last_and_stall();
    test_valid_gaps();
    test_overflow();
    test_reset_mid_block();
    test_len1();
    test_random_blocks();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
